// File: rtl/adc_cap_pkg.sv
// Shared definitions for the ADC frame capture block: sample width and FSM states.
package adc_cap_pkg;
  localparam int ADC_W = 12;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    READOUT = 2'd3
  } state_t;
endpackage

// File: rtl/adc_cap_ram.sv
// Simple dual-port frame buffer: one synchronous write port, one read port with 1-cycle latency.
module adc_cap_ram #(
  parameter int DEPTH  = 1024,
  parameter int DATA_W = 12,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  // rdata holds its value while re is low so a stalled readout keeps its sample
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/adc_frame_capture.sv
// Triggered ADC frame capture with streaming readout.
// Optional auto-trigger timeout is enabled by defining ADC_CAP_TIMEOUT_EN.
module adc_frame_capture
  import adc_cap_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int TO_CYC = 1048576
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [ADC_W-1:0] adc_data,
  input  logic             adc_blank,
  input  logic             arm,
  input  logic             abort,
  input  logic [ADC_W-1:0] trig_level,
  input  logic             trig_fall,
  output logic             busy,
  output logic             done,
  output logic             timed_out,
  output logic [ADC_W-1:0] m_data,
  output logic             m_valid,
  output logic             m_last,
  input  logic             m_ready
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] WR_LAST = AW'(DEPTH - 1);
  localparam logic [AW:0]   RD_LAST = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0]   RD_END  = (AW+1)'(DEPTH);

  if (DEPTH < 16 || DEPTH > 4096 || (DEPTH & (DEPTH - 1)) != 0 || TO_CYC < 1) begin : g_bad_param
    $error("adc_frame_capture: DEPTH must be a power of two in 16..4096 and TO_CYC >= 1");
  end

  state_t           state;
  logic [ADC_W-1:0] prev;
  logic             prev_vld;
  logic [AW-1:0]    wr_addr;
  logic [AW:0]      rd_cnt;
  logic             vld_p1, last_p1;
  logic [ADC_W-1:0] rdata_p1;
  logic             samp_vld, nat_trig, to_hit, trig, arm_ok, adv, rd_vld_p0, ram_we;
  logic [AW-1:0]    ram_waddr;

  assign samp_vld  = !adc_blank;
  assign nat_trig  = prev_vld && (trig_fall ? (prev >= trig_level && adc_data < trig_level)
                                            : (prev < trig_level && adc_data >= trig_level));
  assign trig      = (state == ARMED) && samp_vld && !abort && (nat_trig || to_hit);
  assign arm_ok    = (state == IDLE) && arm && !abort;
  assign ram_we    = trig || ((state == CAPTURE) && samp_vld);
  assign ram_waddr = (state == CAPTURE) ? wr_addr : '0;
  assign adv       = !m_valid || m_ready;
  assign rd_vld_p0 = (state == READOUT) && (rd_cnt != RD_END) && adv;

  adc_cap_ram #(.DEPTH(DEPTH), .DATA_W(ADC_W)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (adc_data),
    .re    (rd_vld_p0),
    .raddr (rd_cnt[AW-1:0]),
    .rdata (rdata_p1)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      m_valid  <= 1'b0;
      m_last   <= 1'b0;
      m_data   <= '0;
      prev     <= '0;
      prev_vld <= 1'b0;
      wr_addr  <= '0;
      rd_cnt   <= '0;
      vld_p1   <= 1'b0;
      last_p1  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state   <= IDLE;
        busy    <= 1'b0;
        m_valid <= 1'b0;
        m_last  <= 1'b0;
        vld_p1  <= 1'b0;
        last_p1 <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (arm_ok) begin
              state    <= ARMED;
              busy     <= 1'b1;
              prev_vld <= 1'b0;
            end
          end
          ARMED: begin
            if (!samp_vld) begin
              prev_vld <= 1'b0;
            end else if (trig) begin
              state   <= CAPTURE;
              wr_addr <= AW'(1);
            end else begin
              prev     <= adc_data;
              prev_vld <= 1'b1;
            end
          end
          CAPTURE: begin
            if (samp_vld) begin
              wr_addr <= wr_addr + 1'b1;
              if (wr_addr == WR_LAST) begin
                state  <= READOUT;
                rd_cnt <= '0;
              end
            end
          end
          READOUT: begin
            // p0: RAM read issue -> p1: RAM output -> output register
            if (adv) begin
              m_valid <= vld_p1;
              m_data  <= rdata_p1;
              m_last  <= last_p1;
              vld_p1  <= rd_vld_p0;
              last_p1 <= rd_vld_p0 && (rd_cnt == RD_LAST);
            end
            if (rd_vld_p0) rd_cnt <= rd_cnt + 1'b1;
            if (m_valid && m_ready && m_last) begin
              state   <= IDLE;
              busy    <= 1'b0;
              done    <= 1'b1;
              m_valid <= 1'b0;
              m_last  <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef ADC_CAP_TIMEOUT_EN
  localparam int TW = $clog2(TO_CYC + 1);
  logic [TW-1:0] to_cnt;
  logic          to_flag;

  assign to_hit    = (to_cnt == TW'(TO_CYC));
  assign timed_out = to_flag;

  // Counts cycles spent ARMED; saturates so the force stays pending until a valid sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt  <= '0;
      to_flag <= 1'b0;
    end else if (arm_ok) begin
      to_cnt  <= '0;
      to_flag <= 1'b0;
    end else if (state == ARMED && !abort) begin
      if (!to_hit) to_cnt <= to_cnt + 1'b1;
      if (trig && !nat_trig) to_flag <= 1'b1;
    end else begin
      to_cnt <= '0;
    end
  end
`else
  assign to_hit    = 1'b0;
  assign timed_out = 1'b0;
`endif
endmodule

// File: tb/tb_adc_frame_capture.sv
// Randomized self-checking bench for adc_frame_capture against a frame-level reference model.
module tb_adc_frame_capture;
  localparam int DEPTH  = 16;
  localparam int TO_CYC = 64;
`ifdef ADC_CAP_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk, rst_n;
  logic [11:0] adc_data, trig_level, m_data;
  logic        adc_blank, arm, abort, trig_fall;
  logic        busy, done, timed_out, m_valid, m_last, m_ready;

  adc_frame_capture #(.DEPTH(DEPTH), .TO_CYC(TO_CYC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .adc_data   (adc_data),
    .adc_blank  (adc_blank),
    .arm        (arm),
    .abort      (abort),
    .trig_level (trig_level),
    .trig_fall  (trig_fall),
    .busy       (busy),
    .done       (done),
    .timed_out  (timed_out),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_last     (m_last),
    .m_ready    (m_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [11:0] stim_d[$];
  bit          stim_b[$];
  logic [11:0] got_d[$];
  bit          got_l[$];
  logic [11:0] exp_d[$];
  int          trig_idx, exp_last_n;
  bit          exp_to;
  int          done_cnt, stall_err, first_xfer, last_xfer;
  bit          hit_limit;

  // mode 0: ramp crossing 1000 shortly after arm, 1: sine, 2: constant, 3: random
  function automatic logic [11:0] gen(input int mode, input int n);
    real s;
    case (mode)
      0: return 12'((950 + n) % 4096);
      1: begin
        s = 2048.0 + 1500.0 * $sin(6.2831853 * n / 40.0);
        return 12'($rtoi(s));
      end
      2: return 12'd1234;
      default: return 12'($urandom);
    endcase
  endfunction

  // Reference: the frame is the trigger sample plus the next DEPTH-1 valid samples
  task automatic compute_exp(input bit fall, input logic [11:0] lvl);
    bit havep, started, nat;
    logic [11:0] p, d;
    exp_d.delete();
    trig_idx = -1; exp_to = 1'b0; exp_last_n = -1;
    havep = 1'b0; started = 1'b0; p = '0;
    for (int i = 0; i < stim_d.size(); i++) begin
      if (stim_b[i]) begin
        havep = 1'b0;
        continue;
      end
      d = stim_d[i];
      if (started) begin
        if (exp_d.size() < DEPTH) begin
          exp_d.push_back(d);
          if (exp_d.size() == DEPTH) exp_last_n = i + 1;
        end
        continue;
      end
      nat = havep && (fall ? (p >= lvl && d < lvl) : (p < lvl && d >= lvl));
      if (nat || (TO_EN && i >= TO_CYC)) begin
        started = 1'b1; trig_idx = i; exp_to = !nat;
        exp_d.push_back(d);
      end else begin
        p = d; havep = 1'b1;
      end
    end
  endtask

  task automatic run_frame(input int mode, input bit fall, input logic [11:0] lvl,
                           input int bl_start, input int bl_len, input bit rnd_rdy,
                           input bit arm_rd, input int max_cyc);
    logic [11:0] held_d;
    bit held_l, stalled, arm_rd_done;
    stim_d.delete(); stim_b.delete(); got_d.delete(); got_l.delete();
    done_cnt = 0; stall_err = 0; first_xfer = -1; last_xfer = -1;
    hit_limit = 1'b1; stalled = 1'b0; arm_rd_done = 1'b0; held_d = '0; held_l = 1'b0;
    @(negedge clk);
    trig_fall = fall; trig_level = lvl; adc_blank = 1'b0; adc_data = gen(mode, 0);
    m_ready = 1'b1; arm = 1'b1;
    for (int n = 1; n <= max_cyc; n++) begin
      @(negedge clk);
      arm = 1'b0;
      if (done) done_cnt++;
      if (stalled && (m_valid !== 1'b1 || m_data !== held_d || m_last !== held_l)) stall_err++;
      if (done_cnt > 0) begin
        hit_limit = 1'b0;
        break;
      end
      adc_blank = (n >= bl_start) && (n < bl_start + bl_len);
      adc_data  = adc_blank ? 12'($urandom) : gen(mode, n);
      stim_d.push_back(adc_data);
      stim_b.push_back(adc_blank);
      m_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      if (arm_rd && m_valid && !arm_rd_done) begin
        arm = 1'b1; arm_rd_done = 1'b1;
      end
      if (m_valid && m_ready) begin
        got_d.push_back(m_data); got_l.push_back(m_last);
        if (first_xfer < 0) first_xfer = n;
        last_xfer = n;
      end
      stalled = m_valid && !m_ready; held_d = m_data; held_l = m_last;
    end
    arm = 1'b0; m_ready = 1'b1; adc_blank = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    compute_exp(fall, lvl);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; arm = 1'b0; abort = 1'b0; adc_data = '0; adc_blank = 1'b0;
    trig_level = '0; trig_fall = 1'b0; m_ready = 1'b1;
    #12;
    n_checks++;
    if ({busy, done, timed_out, m_valid, m_last, m_data} !== 17'd0)
      $display("FAIL reset_outputs: got %b, expected all zero", {busy, done, timed_out, m_valid, m_last, m_data});
    else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) $display("FAIL reset_idle_busy: got %b, expected 0", busy);
    else n_pass++;
  endtask

  task automatic check_frame(input string name);
    int bad;
    bad = 0;
    n_checks++;
    if (hit_limit) $display("FAIL %s_limit: no done within cycle budget", name);
    else n_pass++;
    n_checks++;
    if (got_d.size() != DEPTH) $display("FAIL %s_count: got %0d transfers, expected %0d", name, got_d.size(), DEPTH);
    else n_pass++;
    for (int i = 0; i < DEPTH; i++) begin
      if (i >= got_d.size() || i >= exp_d.size()) bad++;
      else if (got_d[i] !== exp_d[i] || got_l[i] !== (i == DEPTH - 1)) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL %s_data: %0d bad samples/last flags, expected 0 (first got %0d exp %0d)",
                           name, bad, got_d.size() > 0 ? got_d[0] : -1, exp_d.size() > 0 ? exp_d[0] : -1);
    else n_pass++;
    n_checks++;
    if (done_cnt != 1) $display("FAIL %s_done: got %0d done pulses, expected 1", name, done_cnt);
    else n_pass++;
    n_checks++;
    if (timed_out !== exp_to) $display("FAIL %s_timed_out: got %b, expected %b", name, timed_out, exp_to);
    else n_pass++;
  endtask

  task automatic test_ramp_rise();
    run_frame(0, 1'b0, 12'd1000, 1 << 30, 0, 1'b0, 1'b0, 400);
    check_frame("ramp");
    n_checks++;
    if (got_d.size() != DEPTH || got_d[0] !== 12'd1000 || got_d[DEPTH-1] !== 12'(1000 + DEPTH - 1))
      $display("FAIL ramp_bounds: got first %0d last %0d, expected 1000 and %0d",
               got_d.size() > 0 ? got_d[0] : -1, got_d.size() > 0 ? got_d[got_d.size()-1] : -1, 1000 + DEPTH - 1);
    else n_pass++;
    n_checks++;
    if (last_xfer - first_xfer != DEPTH - 1)
      $display("FAIL ramp_throughput: got span %0d cycles, expected %0d", last_xfer - first_xfer, DEPTH - 1);
    else n_pass++;
    n_checks++;
    if (first_xfer < 0 || first_xfer - exp_last_n > 4)
      $display("FAIL ramp_latency: got first valid at %0d, last capture at %0d, expected gap <= 4", first_xfer, exp_last_n);
    else n_pass++;
  endtask

  task automatic test_blank_mid();
    run_frame(0, 1'b0, 12'd1000, 55, 8, 1'b0, 1'b0, 400);
    check_frame("blank");
    n_checks++;
    if (got_d.size() != DEPTH || got_d[4] !== 12'd1004 || got_d[5] !== 12'd1013)
      $display("FAIL blank_gap: got [4]=%0d [5]=%0d, expected 1004 and 1013",
               got_d.size() > 5 ? got_d[4] : -1, got_d.size() > 5 ? got_d[5] : -1);
    else n_pass++;
  endtask

  task automatic test_fall_sine();
    run_frame(1, 1'b1, 12'd2048, 1 << 30, 0, 1'b0, 1'b0, 400);
    check_frame("sine");
    n_checks++;
    if (got_d.size() == 0 || trig_idx < 1 || got_d[0] >= 12'd2048 || stim_d[trig_idx-1] < 12'd2048)
      $display("FAIL sine_edge: got sample0 %0d prev %0d, expected <2048 and >=2048",
               got_d.size() > 0 ? got_d[0] : -1, trig_idx > 0 ? stim_d[trig_idx-1] : -1);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    for (int k = 0; k < 3; k++) begin
      run_frame(3, 1'($urandom_range(0, 1)), 12'($urandom_range(500, 3500)), 1 << 30, 0, 1'b1, 1'b0, 3000);
      check_frame("bp");
      n_checks++;
      if (stall_err != 0) $display("FAIL bp_stall: got %0d unstable stalled cycles, expected 0", stall_err);
      else n_pass++;
    end
  endtask

  task automatic test_abort();
    int seen;
    @(negedge clk);
    trig_fall = 1'b0; trig_level = 12'd1000; adc_blank = 1'b0; adc_data = gen(0, 0); arm = 1'b1;
    for (int n = 1; n <= 56; n++) begin
      @(negedge clk);
      arm = 1'b0; adc_data = gen(0, n);
    end
    n_checks++;
    if (busy !== 1'b1) $display("FAIL abort_precond_busy: got %b, expected 1", busy);
    else n_pass++;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_checks++;
    if ({busy, m_valid, m_last} !== 3'b000) $display("FAIL abort_idle: got busy/valid/last %b, expected 000", {busy, m_valid, m_last});
    else n_pass++;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      adc_data = 12'($urandom);
      if (done || m_valid) seen++;
    end
    arm = 1'b1; abort = 1'b1;
    @(negedge clk);
    arm = 1'b0; abort = 1'b0;
    if (done) seen++;
    n_checks++;
    if (seen != 0) $display("FAIL abort_no_done: got %0d cycles with done/m_valid, expected 0", seen);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL arm_abort_same: got busy %b, expected 0", busy);
    else n_pass++;
    run_frame(0, 1'b0, 12'd1000, 1 << 30, 0, 1'b0, 1'b1, 400);
    check_frame("arm_in_readout");
    n_checks++;
    if (busy !== 1'b0) $display("FAIL arm_in_readout_busy: got %b, expected 0", busy);
    else n_pass++;
  endtask

  task automatic test_timeout();
`ifdef ADC_CAP_TIMEOUT_EN
    run_frame(2, 1'b0, 12'd1000, 1 << 30, 0, 1'b0, 1'b0, 400);
    check_frame("timeout");
    n_checks++;
    if (trig_idx != TO_CYC || timed_out !== 1'b1)
      $display("FAIL timeout_point: got model idx %0d timed_out %b, expected %0d and 1", trig_idx, timed_out, TO_CYC);
    else n_pass++;
    @(negedge clk);
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    n_checks++;
    if (timed_out !== 1'b0) $display("FAIL timeout_clear: got %b, expected 0 after arm", timed_out);
    else n_pass++;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
`else
    @(negedge clk);
    trig_fall = 1'b0; trig_level = 12'd1000; adc_blank = 1'b0; adc_data = 12'd1234; arm = 1'b1;
    repeat (3 * TO_CYC) begin
      @(negedge clk);
      arm = 1'b0;
    end
    n_checks++;
    if ({busy, m_valid, timed_out} !== 3'b100)
      $display("FAIL no_timeout: got busy/valid/timed_out %b, expected 100", {busy, m_valid, timed_out});
    else n_pass++;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
`endif
  endtask

  task automatic test_reset_midframe();
    int seen;
    // leave a nonzero m_data from the previous frame so the reset clear is visible
    @(negedge clk);
    trig_fall = 1'b0; trig_level = 12'd1000; adc_blank = 1'b0; adc_data = gen(0, 0); arm = 1'b1;
    for (int n = 1; n <= 55; n++) begin
      @(negedge clk);
      arm = 1'b0; adc_data = gen(0, n);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, timed_out, m_valid, m_last, m_data} !== 17'd0)
      $display("FAIL reset_mid: got %b, expected all zero", {busy, done, timed_out, m_valid, m_last, m_data});
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      adc_data = gen(0, 60);
      if (busy || m_valid || done) seen++;
    end
    n_checks++;
    if (seen != 0) $display("FAIL reset_discard: got %0d active cycles, expected 0", seen);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_ramp_rise();
    test_blank_mid();
    test_fall_sine();
    test_backpressure();
    test_abort();
    test_timeout();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
